// File: rtl/dac_bus_deinterleave.sv
// Receive-side pairing checker for the fast DAC DDR bus: pairs CHB/CHA words, undoes the
// negative-slope code, tracks lock. Define DAC_BUS_CHK_STATS_EN to build err_o/err_cnt_o.
module dac_bus_deinterleave #(
   parameter int DW       = 14,
   parameter int LOCK_CNT = 4,
   parameter int ERR_W    = 16
) (
   input  logic             dac_clk_i,
   input  logic             dac_rst_i,
   input  logic [DW-1:0]    dac_dat_i,
   input  logic             dac_sel_i,
   input  logic             dac_wrt_i,
   input  logic             dac_ic_rst_i,
   output logic [DW-1:0]    dat_a_o,
   output logic [DW-1:0]    dat_b_o,
   output logic             dat_vld_o,
   output logic             lock_o,
   output logic             err_o,
   output logic [ERR_W-1:0] err_cnt_o
);

   typedef enum logic [1:0] {HUNT, WAIT_A, WAIT_B} state_t;

   localparam logic [3:0] LOCK_V = 4'(LOCK_CNT);

   state_t        state;
   logic [DW-1:0] dat_r;
   logic          sel_r;
   logic          wrt_r;
   logic [DW-1:0] hold_b;
   logic [3:0]    good_cnt;
   logic [3:0]    good_nxt;
   logic          seq_err;

   function automatic logic [DW-1:0] conv(input logic [DW-1:0] w);
      return {w[DW-1], ~w[DW-2:0]};
   endfunction

   always_ff @(posedge dac_clk_i or posedge dac_rst_i) begin
      if (dac_rst_i) begin
         dat_r <= '0;
         sel_r <= 1'b0;
         wrt_r <= 1'b0;
      end else begin
         dat_r <= dac_dat_i;
         sel_r <= dac_sel_i;
         wrt_r <= dac_wrt_i && !dac_ic_rst_i;
      end
   end

   always_comb begin
      good_nxt = (good_cnt == LOCK_V) ? good_cnt : good_cnt + 4'd1;
      seq_err  = wrt_r && !dac_ic_rst_i &&
                 (((state == WAIT_A) && sel_r) || ((state == WAIT_B) && !sel_r));
   end

   always_ff @(posedge dac_clk_i or posedge dac_rst_i) begin
      if (dac_rst_i) begin
         state     <= HUNT;
         hold_b    <= '0;
         good_cnt  <= '0;
         dat_a_o   <= '0;
         dat_b_o   <= '0;
         dat_vld_o <= 1'b0;
         lock_o    <= 1'b0;
      end else begin
         dat_vld_o <= 1'b0;
         if (dac_ic_rst_i) begin
            state    <= HUNT;
            good_cnt <= '0;
            lock_o   <= 1'b0;
         end else if (seq_err) begin
            good_cnt <= '0;
            lock_o   <= 1'b0;
            if (state == WAIT_A) hold_b <= dat_r;
         end else if (wrt_r) begin
            // Errors are filtered above, so WAIT_A here always sees CHA and WAIT_B sees CHB.
            case (state)
               HUNT: begin
                  if (sel_r) begin
                     hold_b <= dat_r;
                     state  <= WAIT_A;
                  end
               end
               WAIT_A: begin
                  dat_b_o   <= conv(hold_b);
                  dat_a_o   <= conv(dat_r);
                  dat_vld_o <= 1'b1;
                  good_cnt  <= good_nxt;
                  if (good_nxt == LOCK_V) lock_o <= 1'b1;
                  state     <= WAIT_B;
               end
               WAIT_B: begin
                  hold_b <= dat_r;
                  state  <= WAIT_A;
               end
               default: state <= HUNT;
            endcase
         end
      end
   end

`ifdef DAC_BUS_CHK_STATS_EN
   always_ff @(posedge dac_clk_i or posedge dac_rst_i) begin
      if (dac_rst_i) begin
         err_o     <= 1'b0;
         err_cnt_o <= '0;
      end else begin
         err_o <= seq_err;
         if (seq_err && (err_cnt_o != '1)) err_cnt_o <= err_cnt_o + ERR_W'(1);
      end
   end
`else
   assign err_o     = 1'b0;
   assign err_cnt_o = '0;
`endif

endmodule

// File: tb/tb_dac_bus_deinterleave.sv
// Scoreboard bench for dac_bus_deinterleave: expected pairs queued at stimulus time,
// popped and compared when dat_vld_o pulses.
module tb_dac_bus_deinterleave;

   localparam int DW    = 14;
   localparam int ERR_W = 16;
`ifdef DAC_BUS_CHK_STATS_EN
   localparam int STATS = 1;
`else
   localparam int STATS = 0;
`endif

   logic             clk = 1'b0;
   logic             rst;
   logic [DW-1:0]    dat;
   logic             sel;
   logic             wrt;
   logic             ic_rst;
   logic [DW-1:0]    dat_a;
   logic [DW-1:0]    dat_b;
   logic             vld;
   logic             lock;
   logic             err;
   logic [ERR_W-1:0] err_cnt;

   dac_bus_deinterleave #(.DW(DW), .LOCK_CNT(4), .ERR_W(ERR_W)) dut (
      .dac_clk_i    (clk),
      .dac_rst_i    (rst),
      .dac_dat_i    (dat),
      .dac_sel_i    (sel),
      .dac_wrt_i    (wrt),
      .dac_ic_rst_i (ic_rst),
      .dat_a_o      (dat_a),
      .dat_b_o      (dat_b),
      .dat_vld_o    (vld),
      .lock_o       (lock),
      .err_o        (err),
      .err_cnt_o    (err_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [DW-1:0] a;
      logic [DW-1:0] b;
      logic          lk;
      int            at;
   } pair_t;

   pair_t sb[$];
   pair_t p;
   int checks   = 0;
   int errors   = 0;
   int cyc      = 0;
   int err_seen = 0;

   always @(posedge clk) cyc++;

   // Offset-binary negative slope: code 0 is the most positive value.
   function automatic logic [DW-1:0] model(input logic [DW-1:0] raw);
      return 14'h1FFF - raw;
   endfunction

   always @(negedge clk) begin
      if (err === 1'b1) err_seen++;
      if (vld === 1'b1) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_pair got a=%h b=%h at cycle %0d, none expected", dat_a, dat_b, cyc);
         end else begin
            p = sb.pop_front();
            if (dat_a !== p.a || dat_b !== p.b || lock !== p.lk || cyc != p.at) begin
               errors++;
               $display("FAIL pair got a=%h b=%h lock=%b cyc=%0d expected a=%h b=%h lock=%b cyc=%0d",
                        dat_a, dat_b, lock, cyc, p.a, p.b, p.lk, p.at);
            end
         end
      end
   end

   task automatic send(input logic s, input logic [DW-1:0] d, input logic w);
      @(negedge clk);
      sel = s;
      dat = d;
      wrt = w;
   endtask

   task automatic send_pair(input logic [DW-1:0] b_raw, input logic [DW-1:0] a_raw, input logic lk);
      send(1'b1, b_raw, 1'b1);
      send(1'b0, a_raw, 1'b1);
      sb.push_back('{a: model(a_raw), b: model(b_raw), lk: lk, at: cyc + 2});
   endtask

   task automatic drain(input string name);
      repeat (4) send(1'b0, '0, 1'b0);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL %s_missing_pairs got %0d outstanding, expected 0", name, sb.size());
      end
      sb.delete();
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      wrt = 1'b0;
      ic_rst = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      sb.delete();
   endtask

   task automatic check_val(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic test_reset();
      do_reset();
      check_val("reset_dat_a", int'(dat_a), 0);
      check_val("reset_dat_b", int'(dat_b), 0);
      check_val("reset_vld", int'(vld), 0);
      check_val("reset_lock", int'(lock), 0);
      check_val("reset_err", int'(err), 0);
      check_val("reset_err_cnt", int'(err_cnt), 0);
   endtask

   task automatic test_clean_stream();
      int e0;
      do_reset();
      e0 = err_seen;
      for (int i = 0; i < 4; i++) send_pair(14'h0000, 14'h3FFF, (i == 3));
      drain("clean");
      check_val("clean_lock", int'(lock), 1);
      check_val("clean_err_cnt", int'(err_cnt), 0);
      check_val("clean_err_pulses", err_seen - e0, 0);
   endtask

   task automatic test_dup_b();
      int e0;
      e0 = err_seen;
      check_val("dup_pre_lock", int'(lock), 1);
      send(1'b1, 14'h0000, 1'b1);
      send(1'b1, 14'h3FFF, 1'b1);
      send(1'b0, 14'h1FFF, 1'b1);
      sb.push_back('{a: model(14'h1FFF), b: model(14'h3FFF), lk: 1'b0, at: cyc + 2});
      @(negedge clk);
      check_val("dup_err_pulse", int'(err), STATS);
      check_val("dup_lock_drop", int'(lock), 0);
      drain("dup");
      check_val("dup_err_pulses", err_seen - e0, STATS);
      check_val("dup_err_cnt", int'(err_cnt), STATS);
      check_val("dup_lock_after", int'(lock), 0);
   endtask

   task automatic test_hunt_discard();
      int e0;
      do_reset();
      e0 = err_seen;
      send(1'b0, 14'h2000, 1'b1);
      send_pair(14'h1FFF, 14'h2000, 1'b0);
      drain("hunt");
      check_val("hunt_err_pulses", err_seen - e0, 0);
      check_val("hunt_err_cnt", int'(err_cnt), 0);
   endtask

   task automatic test_write_gaps();
      int e0;
      e0 = err_seen;
      send(1'b1, 14'h0123, 1'b1);
      for (int i = 0; i < 3; i++) send(i[0], DW'($urandom), 1'b0);
      send(1'b0, 14'h0456, 1'b1);
      sb.push_back('{a: model(14'h0456), b: model(14'h0123), lk: 1'b0, at: cyc + 2});
      drain("gaps");
      check_val("gaps_err_pulses", err_seen - e0, 0);
   endtask

   task automatic test_reset_mid_pair();
      int e0;
      send(1'b1, 14'h0100, 1'b1);
      @(posedge clk);
      #2;
      rst = 1'b1;
      wrt = 1'b0;
      #1;
      check_val("async_dat_a", int'(dat_a), 0);
      check_val("async_dat_b", int'(dat_b), 0);
      check_val("async_vld", int'(vld), 0);
      check_val("async_lock", int'(lock), 0);
      check_val("async_err_cnt", int'(err_cnt), 0);
      @(negedge clk);
      rst = 1'b0;
      e0 = err_seen;
      send(1'b0, 14'h0200, 1'b1);
      drain("after_reset");
      check_val("after_reset_err_pulses", err_seen - e0, 0);
   endtask

   task automatic test_flush();
      int e0;
      do_reset();
      send_pair(14'h0000, 14'h3FFF, 1'b0);
      for (int i = 0; i < 3; i++) send(1'b0, 14'h0010, 1'b1);
      for (int i = 0; i < 4; i++) send_pair(14'h0A00, 14'h0B00, (i == 3));
      drain("flush_pre");
      check_val("flush_pre_lock", int'(lock), 1);
      check_val("flush_pre_err_cnt", int'(err_cnt), 3 * STATS);
      e0 = err_seen;
      @(negedge clk);
      ic_rst = 1'b1;
      sel = 1'b0;
      dat = 14'h1111;
      wrt = 1'b1;
      @(negedge clk);
      ic_rst = 1'b0;
      wrt = 1'b0;
      check_val("flush_lock", int'(lock), 0);
      check_val("flush_err_cnt", int'(err_cnt), 3 * STATS);
      check_val("flush_dat_a_kept", int'(dat_a), int'(model(14'h0B00)));
      check_val("flush_dat_b_kept", int'(dat_b), int'(model(14'h0A00)));
      send(1'b0, 14'h0222, 1'b1);
      send_pair(14'h0333, 14'h0444, 1'b0);
      drain("flush_post");
      check_val("flush_err_pulses", err_seen - e0, 0);
      check_val("flush_post_err_cnt", int'(err_cnt), 3 * STATS);
   endtask

   initial begin
      rst = 1'b1;
      dat = '0;
      sel = 1'b0;
      wrt = 1'b0;
      ic_rst = 1'b0;
      test_reset();
      test_clean_stream();
      test_dup_b();
      test_hunt_discard();
      test_write_gaps();
      test_reset_mid_pair();
      test_flush();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/dac_bus_deinterleave.md
# dac_bus_deinterleave

Receive-side model and checker for the fast DAC DDR bus. It samples the combined 14-bit DAC data bus on the word clock (2× sample rate), qualified by write strobe and channel select. It pairs CHB/CHA words into sample pairs and converts the DAC's unsigned negative-slope code back to 2's complement. It also tracks pairing alignment and lock. It is used as a loopback checker on the DAC output pins and as the bus-side model in DAC-path testbenches.

## Interface
Parameters:
- `DW`, 14, data word width.
- `LOCK_CNT`, 4, consecutive good pairs required to assert lock (1..15).
- `ERR_W`, 16, width of the saturating sequence-error counter.

Ports:
- `dac_clk_i`  in  1  word clock; one bus word per rising edge.
- `dac_rst_i`  in  1  reset, asynchronous, active-high.
- `dac_dat_i`  in  DW  combined DAC bus word, unsigned, negative slope.
- `dac_sel_i`  in  1  channel select: 1 = CHB word, 0 = CHA word.
- `dac_wrt_i`  in  1  write strobe; a word is accepted only when 1.
- `dac_ic_rst_i`  in  1  DAC IC reset; synchronous flush while high.
- `dat_a_o`  out  DW  CHA sample, 2's complement.
- `dat_b_o`  out  DW  CHB sample, 2's complement.
- `dat_vld_o`  out  1  one-cycle pulse when a new pair is presented.
- `lock_o`  out  1  pairing aligned.
- `err_o`  out  1  one-cycle pulse per sequence error.
- `err_cnt_o`  out  ERR_W  saturating sequence-error count.

## Operation
- **Input stage:** `dac_dat_i`, `dac_sel_i` and `dac_wrt_i` are registered every cycle. Only the registered word with wrt=1 ("accepted") is processed. Cycles with wrt=0 are ignored and do not disturb pairing.
- **Conversion:** out = {w[DW-1], ~w[DW-2:0]}. Raw 0x0000 → +8191 (0x1FFF); raw 0x3FFF → −8192 (0x2000); raw 0x2000 → −1; raw 0x1FFF → 0.
- **Pairing order:** a CHB word followed by a CHA word.
- **FSM states:**
  - HUNT: accepted sel=1 → hold B, go WAIT_A. Accepted sel=0 → discard, no error.
  - WAIT_A: accepted sel=0 → emit pair (held B, this A), increment good count, go WAIT_B. Accepted sel=1 → sequence error; the new word replaces held B; stay WAIT_A.
  - WAIT_B: accepted sel=1 → hold B, go WAIT_A. Accepted sel=0 → sequence error; word discarded; stay WAIT_B.
- **Lock:**
  - The good-pair count saturates at LOCK_CNT.
  - `lock_o` sets when the count reaches LOCK_CNT.
  - Any sequence error clears `lock_o` and the good count.
- **Pair output:** pairs are emitted whether or not locked. `dat_a_o`/`dat_b_o` hold their last values between pulses.
- **`dac_ic_rst_i` high:** input stage marked invalid, FSM to HUNT, `lock_o`=0, good count=0, no pair emitted. `err_cnt_o` and the data outputs are retained.
- **Error counter:** increments once per error and saturates at all-ones.
- **Simultaneous events:** `dac_ic_rst_i` has priority over an accepted word in the same cycle. `dac_rst_i` has priority over everything.

## Timing
- **Reset:** on `dac_rst_i`, every output is 0 and the FSM is in HUNT, asynchronously.
- **Pair latency:** CHA word on the bus at edge k (wrt=1) → `dat_vld_o`=1 during the cycle after edge k+1 (2 edges). Data is valid in the same cycle.
- **Lock:** `lock_o` rises in the same cycle as the `dat_vld_o` pulse of the LOCK_CNT-th consecutive good pair.
- **Error:** the offending word at edge k → `err_o` pulse after edge k+1. `err_cnt_o` and `lock_o` are updated in that same cycle.
- **Throughput:** max one pair per 2 cycles. Back-to-back pairs with no gaps produce `dat_vld_o` every other cycle.
- **Flush:** `dac_ic_rst_i` takes effect on the first edge at which it is sampled high. Processing resumes on words accepted after it is low.

## Configuration
- **`DAC_BUS_CHK_STATS_EN` defined:** sequence-error counter and `err_o` are compiled in as described above.
- **Not defined:** no counter register is built. `err_cnt_o` is tied to 0 and `err_o` to 0. Error detection still clears lock and follows the FSM rules unchanged.

## Test plan
1. **Clean stream:** reset, then 4 back-to-back pairs (B raw 0x0000, A raw 0x3FFF), wrt=1 → 4 `dat_vld_o` pulses 2 cycles apart, `dat_b_o`=0x1FFF, `dat_a_o`=0x2000. `lock_o` rises with the 4th pulse; `err_cnt_o`=0.
2. **HUNT discard:** first accepted word has sel=0 (raw 0x2000), then pair (B 0x1FFF, A 0x2000) → the leading word is dropped, no `err_o`. One pulse with `dat_b_o`=0, `dat_a_o`=0x3FFF.
3. **Duplicate B while locked:** when locked, send B 0x0000, B 0x3FFF, A 0x1FFF → `err_o` pulse, `err_cnt_o`=1, `lock_o`=0. The pair emitted is `dat_b_o`=0x2000, `dat_a_o`=0.
4. **Write gaps:** B, then 3 cycles wrt=0 with toggling sel/dat, then A → one pair, `dat_vld_o` 2 edges after A, no error.
5. **Reset and flush:**
   - Assert `dac_rst_i` between B and A → all outputs 0 immediately, and the following A is discarded in HUNT.
   - Separately, `dac_ic_rst_i` pulse with `err_cnt_o`=3 → lock cleared, `err_cnt_o` stays 3.
6. **Macro undefined:** repeat scenario 3 → `err_o` and `err_cnt_o` remain 0 while `lock_o` still drops.
